// File: rtl/vga_pkg.sv
// Shared types for the VGA pixel path.
// Pixel word, screen geometry and FIFO streaming state.
package vga_pkg;
  typedef logic [15:0] pixel_t;

  localparam int H_TOTAL = 640;
  localparam int V_TOTAL = 480;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } fifo_state_t;
endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port word store, one write port, one registered read port.
// Contents carry no reset so the array maps onto block RAM.
module fifo_ram #(
  parameter int DEPTH = 512,
  parameter int WIDTH = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk_100,
  input  logic             we,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             re,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);
  logic [WIDTH-1:0] mem [DEPTH];

  // Read-before-write: a same-address read returns the old word.
  always_ff @(posedge clk_100) begin
    if (we) mem[wr_addr] <= wr_data;
    if (re) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/pixel_fifo_unpacker.sv
// Word FIFO between the SDRAM frame reader and VGA output;
// splits each 32-bit word into two 16-bit pixels, upper half first.
module pixel_fifo_unpacker
  import vga_pkg::*;
#(
  parameter int DEPTH       = 512,
  parameter int FULL_MARGIN = 8,
  parameter int PREFILL     = 64,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic          clk_100,
  input  logic          Reset_h,
  input  logic          push,
  input  logic [31:0]   buffer_data,
  output logic          buffer_full,
  input  logic          frame_start,
  input  logic          pixel_req,
  output pixel_t        pixel_out,
  output logic          pixel_valid,
  output logic          underflow,
  output logic          overflow,
  output logic [LW-1:0] level
);
  localparam logic [LW-1:0] LVL_MAX = LW'(DEPTH);
  localparam logic [LW-1:0] FULL_AT = LW'(DEPTH - FULL_MARGIN);
  localparam logic [LW-1:0] PRE_LVL = LW'(PREFILL);

  fifo_state_t   state, state_nxt;
  logic          streaming;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [31:0]   head_word;
  logic          head_valid, half_sel;
  logic          take, consume, fetch;
  logic          wr_en, drop, starve;

  // head_word is the RAM's own read register; head_valid qualifies it.
  fifo_ram #(.DEPTH(DEPTH), .WIDTH(32)) u_ram (
    .clk_100 (clk_100),
    .we      (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (buffer_data),
    .re      (fetch),
    .rd_addr (rd_ptr),
    .rd_data (head_word)
  );

  always_ff @(posedge clk_100 or posedge Reset_h) begin
    if (Reset_h) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (level >= PRE_LVL || level == LVL_MAX) state_nxt = STREAM;
      STREAM: state_nxt = STREAM;
      default: state_nxt = IDLE;
    endcase
    if (frame_start) state_nxt = IDLE;
  end

  always_comb begin
    streaming = (state == STREAM);
  end

  assign take    = streaming && pixel_req && head_valid && !frame_start;
  assign starve  = streaming && pixel_req && !head_valid && !frame_start;
  assign consume = take && half_sel;
  assign fetch   = streaming && !frame_start && (level != '0)
                && (!head_valid || consume);
  assign wr_en   = push && !frame_start && (level != LVL_MAX || fetch);
  assign drop    = push && !frame_start && (level == LVL_MAX) && !fetch;

  assign buffer_full = (level >= FULL_AT);

  always_ff @(posedge clk_100 or posedge Reset_h) begin
    if (Reset_h) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      head_valid <= 1'b0;
      half_sel   <= 1'b0;
      underflow  <= 1'b0;
      overflow   <= 1'b0;
    end else if (frame_start) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      head_valid <= 1'b0;
      half_sel   <= 1'b0;
      underflow  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (fetch) rd_ptr <= rd_ptr + 1'b1;
      level <= level + LW'(wr_en) - LW'(fetch);
      if (fetch)        head_valid <= 1'b1;
      else if (consume) head_valid <= 1'b0;
      if (take)   half_sel  <= ~half_sel;
      if (drop)   overflow  <= 1'b1;
      if (starve) underflow <= 1'b1;
    end
  end

  // A starved or idle request emits black rather than stalling the raster.
  always_ff @(posedge clk_100 or posedge Reset_h) begin
    if (Reset_h) begin
      pixel_out   <= '0;
      pixel_valid <= 1'b0;
    end else if (pixel_req && !frame_start) begin
      unique case (1'b1)
        take: begin
          pixel_out   <= half_sel ? head_word[15:0] : head_word[31:16];
          pixel_valid <= 1'b1;
        end
        default: begin
          pixel_out   <= '0;
          pixel_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule
